// File: rtl/window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream, zero padded.
// Ports: clk, reset(async low), px_in/px_valid/px_ready in, win_out/win_en/frame_done out.
module window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [7:0] px_in,
  input  logic              px_valid,
  output logic              px_ready,
  output logic [71:0]       win_out,
  output logic              win_en,
  output logic              frame_done
);

  localparam int SR_LEN = 2*IMG_W+3;
  localparam int NPIX   = IMG_W*IMG_H;
  localparam int CW     = $clog2(NPIX+1);
  localparam int RW     = $clog2(IMG_H);
  localparam int XW     = $clog2(IMG_W);

  localparam logic [CW-1:0] PRIME_LAST = CW'(IMG_W);
  localparam logic [CW-1:0] PIX_LAST   = CW'(NPIX-1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H-1);
  localparam logic [XW-1:0] COL_LAST   = XW'(IMG_W-1);

  typedef enum logic [1:0] {
    PRIME,
    STREAM,
    FLUSH
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          shift;
  logic          emit;

  logic [7:0]    sr     [SR_LEN];
  logic [7:0]    sr_nxt [SR_LEN];
  logic [RW-1:0] row;
  logic [XW-1:0] col;
  logic [71:0]   win_nxt;

  logic top_ok;
  logic bot_ok;
  logic lft_ok;
  logic rgt_ok;

  // cnt: accepted pixel index in PRIME/STREAM,
  // flush window index in FLUSH
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift     = 1'b0;
    emit      = 1'b0;
    px_ready  = 1'b0;
    unique case (state)
      PRIME: begin
        px_ready = 1'b1;
        if (px_valid) begin
          shift   = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == PRIME_LAST)
            state_nxt = STREAM;
        end
      end
      STREAM: begin
        px_ready = 1'b1;
        if (px_valid) begin
          shift = 1'b1;
          emit  = 1'b1;
          if (cnt == PIX_LAST) begin
            state_nxt = FLUSH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      FLUSH: begin
        shift = 1'b1;
        emit  = 1'b1;
        if (cnt == FLUSH_LAST) begin
          state_nxt = PRIME;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = PRIME;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PRIME;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Window is built from the post-shift contents
  // so it is registered on the same edge.
  always_comb begin
    sr_nxt[0] = (state == FLUSH) ? 8'h00 : px_in;
    for (int i = 1; i < SR_LEN; i++)
      sr_nxt[i] = sr[i-1];
  end

  // Masks also hide stale data from the previous
  // frame and wrap-around from adjacent rows.
  assign top_ok = (row != '0);
  assign bot_ok = (row != ROW_LAST);
  assign lft_ok = (col != '0);
  assign rgt_ok = (col != COL_LAST);

  always_comb begin
    win_nxt = {
      (top_ok & lft_ok) ? sr_nxt[2*IMG_W+2] : 8'h00,
      top_ok            ? sr_nxt[2*IMG_W+1] : 8'h00,
      (top_ok & rgt_ok) ? sr_nxt[2*IMG_W]   : 8'h00,
      lft_ok            ? sr_nxt[IMG_W+2]   : 8'h00,
      sr_nxt[IMG_W+1],
      rgt_ok            ? sr_nxt[IMG_W]     : 8'h00,
      (bot_ok & lft_ok) ? sr_nxt[2]         : 8'h00,
      bot_ok            ? sr_nxt[1]         : 8'h00,
      (bot_ok & rgt_ok) ? sr_nxt[0]         : 8'h00
    };
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SR_LEN; i++)
        sr[i] <= 8'h00;
      win_out    <= '0;
      win_en     <= 1'b0;
      frame_done <= 1'b0;
      row        <= '0;
      col        <= '0;
    end else begin
      if (shift)
        sr <= sr_nxt;
      win_en     <= emit;
      frame_done <= emit && (row == ROW_LAST) &&
                    (col == COL_LAST);
      if (emit) begin
        win_out <= win_nxt;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels (>=3).
REQ-002 Parameter IMG_H, default 8, image height in pixels (>=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 px_in  input  8  signed input pixel, raster order (row-major, row 0 first).
REQ-006 px_valid  input  1  px_in valid; pixel accepted on a rising edge where px_valid=1 and px_ready=1.
REQ-007 px_ready  output  1  block can accept a pixel this cycle.
REQ-008 win_out  output  72  3x3 window {p00,p01,p02,p10,p11,p12,p20,p21,p22}; p00 = top-left in bits [71:64], p22 in [7:0]; matches the arithmetic core `in` / weight packing.
REQ-009 win_en  output  1  win_out valid this cycle; drives the core's `en`.
REQ-010 frame_done  output  1  one-cycle pulse with the last window of a frame.

Function
REQ-011 Window for output position (r,c) SHALL be centred on pixel (r,c); stride 1; zero padding of width 1 on all sides; exactly IMG_H*IMG_W windows per frame, raster order.
REQ-012 Storage SHALL be a shift register of 2*IMG_W+3 pixels; sr[0] = newest pixel.
REQ-013 Taps: top row = sr[2W+2],sr[2W+1],sr[2W]; middle = sr[W+2],sr[W+1],sr[W]; bottom = sr[2],sr[1],sr[0].
REQ-014 Masking: c==0 -> left column zero; c==IMG_W-1 -> right column zero; r==0 -> top row zero; r==IMG_H-1 -> bottom row zero; corners combine.
REQ-015 States: PRIME, STREAM, FLUSH.
REQ-016 PRIME: px_ready=1; each accepted pixel shifts in; no window; after the (IMG_W+1)-th accept -> STREAM.
REQ-017 STREAM: px_ready=1; each accept shifts in pixel k and emits window for raster position k-(IMG_W+1); after accept of pixel IMG_H*IMG_W-1 -> FLUSH.
REQ-018 FLUSH: px_ready=0; every cycle shifts in zero and emits one window; after IMG_W+1 windows -> PRIME, row/col counters cleared.
REQ-019 win_out/win_en SHALL be registered: win_en high in the cycle following the accepting edge (STREAM) or the flush-shift edge (FLUSH); win_out holds its last value when win_en=0.
REQ-020 Cycles with px_valid=0 in PRIME/STREAM SHALL shift nothing and produce win_en=0; stall is lossless.
REQ-021 px_valid=1 while px_ready=0 SHALL not accept; the producer holds px_in.
REQ-022 frame_done SHALL assert in the same cycle as win_en for position (IMG_H-1,IMG_W-1), and at no other time.
REQ-023 Back-to-back frames: stale shift-register contents SHALL be fully suppressed by REQ-014 masking; no clearing cycle required; first pixel of the next frame is accepted the cycle after FLUSH ends.
REQ-024 Output row/column counters SHALL wrap col IMG_W-1 -> 0 with row+1, and row IMG_H-1 -> 0 at frame end.

Reset
REQ-025 reset=0 SHALL immediately force state PRIME, counters 0, shift register 0, win_out=0, win_en=0, frame_done=0; px_ready=1 once reset=1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the next accepted pixel is treated as pixel (0,0).

Verification
REQ-027 8x8, ramp px_in=0x00..0x3F, px_valid held 1 -> first win_en the cycle after the 10th accept, window (0,0) = {00,00,00,00,00,01,00,08,09}; 64 win_en total; px_ready low 9 cycles.
REQ-028 Same ramp -> window (3,4) = {13,14,15,1B,1C,1D,23,24,25}; window (7,7) = {36,37,00,3E,3F,00,00,00,00} with frame_done=1.
REQ-029 Random px_valid gaps -> identical window sequence to REQ-027, one win_en per accept in STREAM, no window emitted during gaps.
REQ-030 Two frames back-to-back (ramp then all 0x7F) -> frame 2 window (0,0) = {00,00,00,00,7F,7F,00,7F,7F}; no frame-1 data visible.
REQ-031 reset pulsed low after 30 accepts, then ramp restarted -> win_en drops at once; output identical to REQ-027 thereafter.
REQ-032 Chained into the arithmetic core (bias 0, ReLU on, maxpool off) with the 8x8 test image -> 64 core outputs match the golden output file exactly.
